elastic_pipe_reg: RTL and testbench

- Parametrised elastic pipeline register placed between processor stages: IF/ID, ID/EX, EX/MEM and MEM/WB.
- Replaces the hand-written per-stage valid/done registers with one block that carries a payload and a PC tag.
- Uses a proper valid/ready handshake, a DEPTH-entry elastic buffer, and a pipeline flush for branch redirect.
- Every stage boundary in the core instantiates this block.

---
 rtl/elastic_pipe_reg.sv | 123 ++++++++++++
 tb/tb_elastic_pipe_reg.sv | 235 +++++++++++++++++++++++
 2 files changed

// File: rtl/elastic_pipe_reg.sv
// elastic_pipe_reg: elastic pipeline register for a processor stage boundary
// (IF/ID, ID/EX, EX/MEM, MEM/WB).
//
// A DEPTH-entry circular buffer holds {pc, data} pairs. The upstream side
// uses a valid/ready handshake, and the downstream side sees the head entry.
// Pushed entries become visible one cycle later. There is no bypass from
// input to output. When the buffer is full, a push and a pop can happen in
// the same cycle (pop-through). Flush has priority over push and pop. It
// empties the buffer and rewinds both pointers.
//
// Ports:
//   clk, reset        clock; synchronous active-high reset
//   flush             discard every held entry and any entry offered now
//   in_valid/in_ready upstream handshake; in_pc/in_data carry the entry
//   out_valid/out_ready downstream handshake; out_pc/out_data show the head
//   occupancy         number of entries currently held
//
// Optional build macro ELASTIC_PIPE_STATS_EN adds three saturating 32-bit
// counters that only reset clears:
//   stall_cycles      cycles with in_valid && !in_ready && !flush
//   bubble_cycles     cycles with out_ready && !out_valid
//   flushed_entries   sum of occupancy + in_valid over flush cycles
module elastic_pipe_reg #(
  parameter int DATA_WIDTH = 64,
  parameter int PC_WIDTH   = 64,
  parameter int DEPTH      = 2,
  parameter int CNT_WIDTH  = $clog2(DEPTH + 1)
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  flush,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [PC_WIDTH-1:0]   in_pc,
  input  logic [DATA_WIDTH-1:0] in_data,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [PC_WIDTH-1:0]   out_pc,
  output logic [DATA_WIDTH-1:0] out_data,
  output logic [CNT_WIDTH-1:0]  occupancy
`ifdef ELASTIC_PIPE_STATS_EN
  ,
  output logic [31:0]           stall_cycles,
  output logic [31:0]           bubble_cycles,
  output logic [31:0]           flushed_entries
`endif
);

  localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  typedef struct packed {
    logic [PC_WIDTH-1:0]   pc;
    logic [DATA_WIDTH-1:0] data;
  } entry_t;

  entry_t             mem [DEPTH];
  logic [PTR_W-1:0]   rd_ptr, wr_ptr;
  logic [CNT_WIDTH-1:0] count;
  logic               push, pop;

  // Wrap explicitly at DEPTH-1 so that depths that are not a power of two work.
  function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
    return (p == PTR_W'(DEPTH - 1)) ? '0 : p + PTR_W'(1);
  endfunction

  assign out_valid = (count != '0);
  // Pop-through: a full buffer still accepts when its head leaves this cycle.
  assign in_ready  = (count < CNT_WIDTH'(DEPTH)) || (out_valid && out_ready);
  assign push      = in_valid && in_ready && !flush;
  assign pop       = out_valid && out_ready && !flush;

  // The head is read straight from storage. After a flush it shows stale data
  // with out_valid=0, and consumers ignore it.
  assign out_pc    = mem[rd_ptr].pc;
  assign out_data  = mem[rd_ptr].data;
  assign occupancy = count;

  always_ff @(posedge clk) begin
    if (reset) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      count  <= '0;
      // Clearing storage makes the head read back as zero after reset.
      for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
    end else if (flush) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) begin
        mem[wr_ptr] <= '{pc: in_pc, data: in_data};
        wr_ptr      <= ptr_inc(wr_ptr);
      end
      if (pop) rd_ptr <= ptr_inc(rd_ptr);
      case ({push, pop})
        2'b10:   count <= count + CNT_WIDTH'(1);
        2'b01:   count <= count - CNT_WIDTH'(1);
        default: count <= count;
      endcase
    end
  end

`ifdef ELASTIC_PIPE_STATS_EN
  logic [32:0] fl_sum;
  assign fl_sum = {1'b0, flushed_entries} + 33'(count) + 33'(in_valid);

  always_ff @(posedge clk) begin
    if (reset) begin
      stall_cycles    <= '0;
      bubble_cycles   <= '0;
      flushed_entries <= '0;
    end else begin
      if (in_valid && !in_ready && !flush && stall_cycles != '1)
        stall_cycles <= stall_cycles + 32'd1;
      if (out_ready && !out_valid && bubble_cycles != '1)
        bubble_cycles <= bubble_cycles + 32'd1;
      if (flush)
        flushed_entries <= fl_sum[32] ? '1 : fl_sum[31:0];
    end
  end
`endif

endmodule

// File: tb/tb_elastic_pipe_reg.sv
// Bench for elastic_pipe_reg. It runs DEPTH=1, 2 and 3 instances on shared
// inputs. Each instance has its own queue-based reference model that is
// checked every cycle, and directed checks follow the test plan.
module tb_elastic_pipe_reg;
  localparam int PW = 32;
  localparam int DW = 16;

  logic clk = 1'b0;
  logic reset = 1'b1;
  logic flush = 1'b0;
  logic in_valid = 1'b0;
  logic out_ready = 1'b0;
  logic [PW-1:0] in_pc = '0;
  logic [DW-1:0] in_data = '0;

  logic          ir   [3];
  logic          ov   [3];
  logic [PW-1:0] opc  [3];
  logic [DW-1:0] odat [3];
  logic [3:0]    occ  [3];
`ifdef ELASTIC_PIPE_STATS_EN
  logic [31:0]   sst [3];
  logic [31:0]   sbub[3];
  logic [31:0]   sfl [3];
`endif

  always #5 clk = ~clk;

  for (genvar g = 0; g < 3; g++) begin : g_dut
    localparam int D = g + 1;
    logic [$clog2(D+1)-1:0] occ_l;
    elastic_pipe_reg #(.DATA_WIDTH(DW), .PC_WIDTH(PW), .DEPTH(D)) u_dut (
      .clk(clk), .reset(reset), .flush(flush),
      .in_valid(in_valid), .in_ready(ir[g]), .in_pc(in_pc), .in_data(in_data),
      .out_valid(ov[g]), .out_ready(out_ready), .out_pc(opc[g]), .out_data(odat[g]),
      .occupancy(occ_l)
`ifdef ELASTIC_PIPE_STATS_EN
      , .stall_cycles(sst[g]), .bubble_cycles(sbub[g]), .flushed_entries(sfl[g])
`endif
    );
    assign occ[g] = 4'(occ_l);
  end

  typedef struct packed { logic [PW-1:0] pc; logic [DW-1:0] d; } ent_t;
  ent_t q [3][$];
  int m_stall[3], m_bub[3], m_fl[3];
  int n_cmp = 0;
  int n_err = 0;

  task automatic chk(string tag, logic [63:0] obs, logic [63:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic drv(bit v, logic [PW-1:0] pc, logic [DW-1:0] d, bit ordy, bit fl);
    in_valid = v; in_pc = pc; in_data = d; out_ready = ordy; flush = fl;
  endtask

  // Mid-cycle check of every instance against its queue model.
  task automatic settle();
    #4;
    if (!reset) begin
      for (int i = 0; i < 3; i++) begin
        int n;
        bit er;
        n  = q[i].size();
        er = (n < i + 1) || (n > 0 && out_ready);
        chk($sformatf("in_ready[%0d]", i), 64'(ir[i]), 64'(er));
        chk($sformatf("out_valid[%0d]", i), 64'(ov[i]), 64'(n > 0));
        chk($sformatf("occupancy[%0d]", i), 64'(occ[i]), 64'(n));
        if (n > 0) begin
          chk($sformatf("out_pc[%0d]", i), 64'(opc[i]), 64'(q[i][0].pc));
          chk($sformatf("out_data[%0d]", i), 64'(odat[i]), 64'(q[i][0].d));
        end
`ifdef ELASTIC_PIPE_STATS_EN
        chk($sformatf("stall[%0d]", i), 64'(sst[i]), 64'(m_stall[i]));
        chk($sformatf("bubble[%0d]", i), 64'(sbub[i]), 64'(m_bub[i]));
        chk($sformatf("flushed[%0d]", i), 64'(sfl[i]), 64'(m_fl[i]));
`endif
      end
    end
  endtask

  // Clock edge: advance the models using the inputs sampled at the edge.
  task automatic tick();
    @(posedge clk);
    for (int i = 0; i < 3; i++) begin
      if (reset) begin
        q[i].delete();
        m_stall[i] = 0; m_bub[i] = 0; m_fl[i] = 0;
      end else begin
        int n;
        bit rdy;
        n   = q[i].size();
        rdy = (n < i + 1) || (n > 0 && out_ready);
        if (in_valid && !rdy && !flush) m_stall[i]++;
        if (out_ready && n == 0) m_bub[i]++;
        if (flush) begin
          m_fl[i] += n + int'(in_valid);
          q[i].delete();
        end else begin
          if (n > 0 && out_ready) void'(q[i].pop_front());
          if (in_valid && rdy) q[i].push_back({in_pc, in_data});
        end
      end
    end
    #1;
  endtask

  task automatic cyc();
    settle();
    tick();
  endtask

  initial begin
    logic [DW-1:0] got[$];
    int k;
    bit acc;

    // Reset, then idle.
    drv(0, 0, 0, 0, 0);
    tick(); tick();
    reset = 1'b0;
    settle();
    chk("rst_in_ready", 64'(ir[1]), 64'd1);
    chk("rst_out_valid", 64'(ov[1]), 64'd0);
    chk("rst_occ", 64'(occ[1]), 64'd0);
    chk("rst_out_data", 64'(odat[1]), 64'd0);
    chk("rst_out_pc", 64'(opc[1]), 64'd0);
    tick();

    // Streaming with out_ready held at 1 (DEPTH=2 instance).
    drv(1, 32'h1000, 16'hA, 1, 0); cyc();
    drv(1, 32'h1004, 16'hB, 1, 0); settle();
    chk("stream_head_a", 64'(odat[1]), 64'hA);
    chk("stream_occ", 64'(occ[1]), 64'd1);
    chk("stream_ready", 64'(ir[1]), 64'd1);
    tick();
    drv(1, 32'h1008, 16'hC, 1, 0); settle();
    chk("stream_head_b", 64'(odat[1]), 64'hB);
    chk("stream_pc_b", 64'(opc[1]), 64'h1004);
    tick();
    drv(0, 0, 0, 1, 0); settle();
    chk("stream_head_c", 64'(odat[1]), 64'hC);
    tick();
    settle();
    chk("stream_drained", 64'(ov[1]), 64'd0);
    tick();

    // Backpressure, then pop-through on full.
    drv(1, 32'h2000, 16'hA, 0, 0); cyc();
    drv(1, 32'h2004, 16'hB, 0, 0); cyc();
    drv(1, 32'h2008, 16'hC, 0, 0); settle();
    chk("bp_full_occ", 64'(occ[1]), 64'd2);
    chk("bp_full_ready", 64'(ir[1]), 64'd0);
    tick();
    out_ready = 1'b1; settle();
    chk("bp_popthru_ready", 64'(ir[1]), 64'd1);
    chk("bp_head_a", 64'(odat[1]), 64'hA);
    tick();
    drv(0, 0, 0, 1, 0); settle();
    chk("bp_popthru_occ", 64'(occ[1]), 64'd2);
    chk("bp_head_b", 64'(odat[1]), 64'hB);
    tick();
    settle();
    chk("bp_head_c", 64'(odat[1]), 64'hC);
    tick();
    drv(0, 0, 0, 0, 1); cyc();

    // Flush with two entries held and an input offered.
    drv(1, 32'h3000, 16'h11, 0, 0); cyc();
    drv(1, 32'h3004, 16'h12, 0, 0); cyc();
    drv(1, 32'h3008, 16'hD, 0, 1); cyc();
    drv(0, 0, 0, 0, 0); settle();
    chk("flush_occ", 64'(occ[1]), 64'd0);
    chk("flush_valid", 64'(ov[1]), 64'd0);
    tick();
    drv(1, 32'h300C, 16'hE, 0, 0); cyc();
    drv(0, 0, 0, 0, 0); settle();
    chk("flush_next_head", 64'(odat[1]), 64'hE);
    tick();
    drv(0, 0, 0, 0, 1); cyc();

    // Wrap on DEPTH=3: ten values under random out_ready.
    k = 0;
    for (int c = 0; c < 400 && got.size() < 10; c++) begin
      drv(k < 10, 32'h4000 + 32'(k * 4), DW'(k), 1'($urandom), 0);
      settle();
      if (ov[2] && out_ready) got.push_back(odat[2]);
      acc = in_valid && ir[2];
      tick();
      if (acc) k++;
    end
    chk("wrap_count", 64'(got.size()), 64'd10);
    for (int i = 0; i < got.size(); i++)
      chk($sformatf("wrap_order[%0d]", i), 64'(got[i]), 64'(i));
    drv(0, 0, 0, 0, 1); cyc();

`ifdef ELASTIC_PIPE_STATS_EN
    // Statistics on DEPTH=1: five offers with no consumer, then a flush.
    drv(0, 0, 0, 0, 0); reset = 1'b1; tick(); reset = 1'b0;
    for (int i = 0; i < 5; i++) begin
      drv(1, 32'h5000, 16'h55, 0, 0); cyc();
    end
    drv(1, 32'h5000, 16'h55, 0, 1); cyc();
    drv(0, 0, 0, 0, 0); settle();
    chk("stats_stall", 64'(sst[0]), 64'd4);
    chk("stats_flushed", 64'(sfl[0]), 64'd2);
    tick();
`endif

    // Random traffic with occasional flush and one reset in mid-operation.
    for (int c = 0; c < 400; c++) begin
      drv(1'($urandom), PW'($urandom), DW'($urandom), 1'($urandom),
          ($urandom_range(15) == 0));
      if (c == 200) begin
        reset = 1'b1; tick(); reset = 1'b0;
        drv(0, 0, 0, 0, 0); settle();
        for (int i = 0; i < 3; i++) begin
          chk($sformatf("midrst_data[%0d]", i), 64'(odat[i]), 64'd0);
          chk($sformatf("midrst_pc[%0d]", i), 64'(opc[i]), 64'd0);
        end
        tick();
      end else begin
        cyc();
      end
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
